// File: rtl/result_collect_fifo.sv
// -----------------------------------------------------------------------------
// result_collect_fifo
//
// Collects single-cycle results from the add, mul and sine units. Each result
// goes into a per-unit holding register. A round-robin arbiter moves one held
// result per cycle into a DEPTH-entry FIFO. The CPU reads the head of the FIFO.
// out_fifo_hold tells the operation decoder to stop issuing ops while the
// FIFO, plus everything already held or in flight, could overrun.
//
// Optional feature macro: RESULT_TAG_EN
//   When it is defined, each entry also stores a 2-bit source tag
//   (00 add, 01 mul, 10 sine), and the tag of the head entry is driven on
//   result_src.
//
// Handshake: the *_done inputs are one-cycle valid pulses with no ready.
// The capture stage is always able to accept a result. If a unit sends a new
// result while its previous one is still held, the new value is dropped and
// ovf_err is set. The CPU side works on strobe edges: each rising edge of
// rd_strobe consumes the head entry if there is one.
//
// Ports
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   add_done/add_result, mul_done/mul_result, sine_done/sine_result
//                  unit result pulses and their 32-bit data
//   rd_strobe      CPU read strobe (level; a rising edge pops one entry)
//   result_out     head entry, 0 when the FIFO is empty
//   result_valid   FIFO non-empty
//   fifo_count     number of entries held in the FIFO
//   out_fifo_hold  to decoder: stop issuing ops
//   ovf_err        sticky: a result was lost
//   result_src     (RESULT_TAG_EN only) tag of the head entry
// -----------------------------------------------------------------------------
module result_collect_fifo #(
    parameter int DEPTH       = 8,
    parameter int HOLD_MARGIN = 3
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     add_done,
    input  logic [31:0]              add_result,
    input  logic                     mul_done,
    input  logic [31:0]              mul_result,
    input  logic                     sine_done,
    input  logic [31:0]              sine_result,
    input  logic                     rd_strobe,
    output logic [31:0]              result_out,
    output logic                     result_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     out_fifo_hold,
`ifdef RESULT_TAG_EN
    output logic [1:0]               result_src,
`endif
    output logic                     ovf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef RESULT_TAG_EN
    localparam int EW = 34;
`else
    localparam int EW = 32;
`endif

    // Source index: 0 add, 1 mul, 2 sine (this is also the tag encoding).
    logic [2:0]    done_v;
    logic [31:0]   src_data [3];
    logic [2:0]    pend_q;
    logic [31:0]   hold_q   [3];
    logic [1:0]    last_q;          // last granted source
    logic [2:0]    grant;
    logic [1:0]    grant_idx;
    logic          do_push;
    logic          do_pop;
    logic [31:0]   push_val;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          prev1_q;
    logic          prev2_q;
    logic          ovf_q;

    assign done_v      = {sine_done, mul_done, add_done};
    assign src_data[0] = add_result;
    assign src_data[1] = mul_result;
    assign src_data[2] = sine_result;

    // Round-robin grant. The source after the last winner has the highest
    // priority. Nothing is granted while the FIFO is full, so a held result
    // stays in its holding register until there is space.
    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        if (count_q < CW'(DEPTH)) begin
            case (last_q)
                2'd0: begin
                    if      (pend_q[1]) begin grant = 3'b010; grant_idx = 2'd1; end
                    else if (pend_q[2]) begin grant = 3'b100; grant_idx = 2'd2; end
                    else if (pend_q[0]) begin grant = 3'b001; grant_idx = 2'd0; end
                end
                2'd1: begin
                    if      (pend_q[2]) begin grant = 3'b100; grant_idx = 2'd2; end
                    else if (pend_q[0]) begin grant = 3'b001; grant_idx = 2'd0; end
                    else if (pend_q[1]) begin grant = 3'b010; grant_idx = 2'd1; end
                end
                default: begin
                    if      (pend_q[0]) begin grant = 3'b001; grant_idx = 2'd0; end
                    else if (pend_q[1]) begin grant = 3'b010; grant_idx = 2'd1; end
                    else if (pend_q[2]) begin grant = 3'b100; grant_idx = 2'd2; end
                end
            endcase
        end
    end

    assign do_push  = |grant;
    assign push_val = hold_q[grant_idx];
`ifdef RESULT_TAG_EN
    assign push_entry = {grant_idx, push_val};
`else
    assign push_entry = push_val;
`endif

    // Pop fires on the rising edge of the strobe, seen one cycle late through
    // the two-flop history. A strobe that stays high therefore pops only once.
    assign do_pop = prev1_q & ~prev2_q & (count_q != '0);

    // Capture, arbitration bookkeeping and read-strobe history.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend_q    <= 3'b000;
            hold_q[0] <= '0;
            hold_q[1] <= '0;
            hold_q[2] <= '0;
            last_q    <= 2'd2;
            ovf_q     <= 1'b0;
            prev1_q   <= 1'b0;
            prev2_q   <= 1'b0;
        end else begin
            prev1_q <= rd_strobe;
            prev2_q <= prev1_q;
            if (do_push) begin
                last_q <= grant_idx;
            end
            for (int i = 0; i < 3; i++) begin
                // A granted slot is free again in this cycle, so a new done
                // that arrives with the grant is captured without error.
                if (done_v[i]) begin
                    if (pend_q[i] && !grant[i]) begin
                        ovf_q <= 1'b1;
                    end else begin
                        hold_q[i] <= src_data[i];
                        pend_q[i] <= 1'b1;
                    end
                end else if (grant[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array. It has no reset because an entry is only visible once
    // count and rd_ptr cover it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head         = mem[rd_ptr];
    assign result_valid = (count_q != '0);
    assign result_out   = result_valid ? head[31:0] : 32'd0;
`ifdef RESULT_TAG_EN
    assign result_src   = result_valid ? head[33:32] : 2'd0;
`endif
    assign fifo_count   = count_q;
    assign ovf_err      = ovf_q;

    // Every held result is space the FIFO may still be asked to absorb.
    assign out_fifo_hold = (int'(count_q) + int'(pend_q[0]) + int'(pend_q[1])
                            + int'(pend_q[2])) > (DEPTH - HOLD_MARGIN);

endmodule

// File: tb/tb_result_collect_fifo.sv
module tb_result_collect_fifo;

    localparam int DEPTH       = 8;
    localparam int HOLD_MARGIN = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic        add_done, mul_done, sine_done, rd_strobe;
    logic [31:0] add_result, mul_result, sine_result;
    logic [31:0] result_out;
    logic        result_valid, out_fifo_hold, ovf_err;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef RESULT_TAG_EN
    logic [1:0]  result_src;
`endif

    result_collect_fifo #(.DEPTH(DEPTH), .HOLD_MARGIN(HOLD_MARGIN)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .add_done     (add_done),
        .add_result   (add_result),
        .mul_done     (mul_done),
        .mul_result   (mul_result),
        .sine_done    (sine_done),
        .sine_result  (sine_result),
        .rd_strobe    (rd_strobe),
        .result_out   (result_out),
        .result_valid (result_valid),
        .fifo_count   (fifo_count),
        .out_fifo_hold(out_fifo_hold),
`ifdef RESULT_TAG_EN
        .result_src   (result_src),
`endif
        .ovf_err      (ovf_err)
    );

    // ---------------- reference model ----------------
    // Expected FIFO contents as a queue, plus one held value per unit.
    logic [31:0] exp_q[$];
    bit          m_pend [3];
    logic [31:0] m_val  [3];
    int          m_last;
    bit          m_p1, m_p2, m_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0;
            m_val[i]  = '0;
        end
        m_last = 2;
        m_p1   = 0;
        m_p2   = 0;
        m_ovf  = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_step();
        bit          pop;
        int          g;
        int          idx;
        bit          dn [3];
        logic [31:0] dv [3];
        if (!n_rst) begin
            model_reset();
            return;
        end
        dn[0] = add_done;  dv[0] = add_result;
        dn[1] = mul_done;  dv[1] = mul_result;
        dn[2] = sine_done; dv[2] = sine_result;
        pop = m_p1 && !m_p2 && (exp_q.size() != 0);
        g = -1;
        if (exp_q.size() < DEPTH) begin
            for (int k = 1; k <= 3; k++) begin
                idx = (m_last + k) % 3;
                if (g < 0 && m_pend[idx]) g = idx;
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (g >= 0) begin
            exp_q.push_back(m_val[g]);
            m_pend[g] = 0;
            m_last    = g;
        end
        for (int i = 0; i < 3; i++) begin
            if (dn[i]) begin
                if (m_pend[i]) m_ovf = 1;
                else begin
                    m_pend[i] = 1;
                    m_val[i]  = dv[i];
                end
            end
        end
        m_p2 = m_p1;
        m_p1 = rd_strobe;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int          npend;
        logic [31:0] e_out;
        npend = int'(m_pend[0]) + int'(m_pend[1]) + int'(m_pend[2]);
        e_out = (exp_q.size() != 0) ? exp_q[0] : 32'd0;
        check("result_valid", 32'(result_valid), 32'(exp_q.size() != 0));
        check("result_out", result_out, e_out);
        check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        check("out_fifo_hold", 32'(out_fifo_hold),
              32'((exp_q.size() + npend) > (DEPTH - HOLD_MARGIN)));
        check("ovf_err", 32'(ovf_err), 32'(m_ovf));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive inputs, clock once, check at the next falling edge.
    task automatic cycle(input logic [2:0] dn, input logic [31:0] a, input logic [31:0] m,
                         input logic [31:0] s, input logic rd);
        add_done  = dn[0]; add_result  = a;
        mul_done  = dn[1]; mul_result  = m;
        sine_done = dn[2]; sine_result = s;
        rd_strobe = rd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) cycle(3'b000, 0, 0, 0, rd);
    endtask

    task automatic pop_pulse();
        cycle(3'b000, 0, 0, 0, 1'b1);
        idle(2, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 4; i++) pop_pulse();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_rst = 1'b0;
        add_done = 0; mul_done = 0; sine_done = 0; rd_strobe = 0;
        add_result = 0; mul_result = 0; sine_result = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        check("reset_result_out", result_out, 32'd0);
        n_rst = 1'b1;

        // Single add result: visible two cycles after the done pulse.
        cycle(3'b001, 32'h3F80_0000, 0, 0, 0);
        idle(1, 0);
        check("t1_head", result_out, 32'h3F80_0000);
        idle(1, 0);
        pop_pulse();

        // All three units at once: add, mul, sine order.
        cycle(3'b111, 32'h1, 32'h2, 32'h3, 0);
        idle(4, 0);
        check("t2_count", 32'(fifo_count), 32'd3);
        pop_pulse();
        pop_pulse();
        pop_pulse();

        // Hold threshold: five entries do not raise hold, six do.
        for (int i = 0; i < 5; i++) cycle(3'b001, 32'h100 + i, 0, 0, 0);
        idle(2, 0);
        check("t3_hold5", 32'(out_fifo_hold), 32'd0);
        cycle(3'b010, 0, 32'h200, 0, 0);
        idle(2, 0);
        check("t3_hold6", 32'(out_fifo_hold), 32'd1);
        pop_pulse();
        pop_pulse();
        drain();

        // Held strobe pops once; a second rising edge pops again.
        cycle(3'b111, 32'h11, 32'h22, 32'h33, 0);
        idle(3, 0);
        idle(10, 1);
        check("t4_held", 32'(fifo_count), 32'd2);
        idle(2, 0);
        idle(3, 1);
        check("t4_again", 32'(fifo_count), 32'd1);
        idle(1, 0);
        drain();

        // Full FIFO: a mul result waits, a second one is lost.
        for (int i = 0; i < DEPTH; i++) cycle(3'b001, 32'h500 + i, 0, 0, 0);
        idle(2, 0);
        cycle(3'b010, 0, 32'hAA, 0, 0);
        idle(2, 0);
        check("t5_full", 32'(fifo_count), 32'(DEPTH));
        cycle(3'b010, 0, 32'hBB, 0, 0);
        idle(1, 0);
        check("t5_ovf", 32'(ovf_err), 32'd1);
        pop_pulse();
        idle(2, 0);
        drain();

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 4; i++) cycle(3'b001, 32'h700 + i, 0, 0, 0);
        cycle(3'b010, 0, 32'h777, 0, 0);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check("t6_out", result_out, 32'd0);
        check("t6_valid", 32'(result_valid), 32'd0);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_hold", 32'(out_fifo_hold), 32'd0);
        check("t6_ovf", 32'(ovf_err), 32'd0);
        @(negedge clk);
        idle(2, 0);
        n_rst = 1'b1;
        cycle(3'b001, 32'h1234, 0, 0, 0);
        idle(3, 0);
        check("t6_only", 32'(fifo_count), 32'd1);
        check("t6_head", result_out, 32'h1234);
        drain();

        // Random traffic: a slow reader phase, then a fast reader phase.
        for (int ph = 0; ph < 2; ph++) begin
            logic rd;
            rd = 0;
            for (int i = 0; i < 300; i++) begin
                logic [2:0] dn;
                dn = 3'b000;
                for (int b = 0; b < 3; b++)
                    dn[b] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, (ph == 0) ? 5 : 1) == 0) rd = ~rd;
                cycle(dn, $urandom, $urandom, $urandom, rd);
            end
        end
        idle(2, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
